// File: rtl/mem_rsp_pkg.sv
// Shared types for the data memory responder: FSM state encoding, word geometry
// and the address legality check used by the responder core.
package mem_rsp_pkg;

    typedef enum logic [1:0] {
        RSP_IDLE,
        RSP_WAIT,
        RSP_RESP
    } rsp_state_t;

    localparam int WORD_BYTES = 4;
    localparam int CNT_W      = $clog2(16);

    // Upper address bits are checked rather than aliased onto the array.
    function automatic logic addr_bad(input logic [31:0] addr, input int depth);
        return (addr[1:0] != 2'b00) || ({2'b00, addr[31:2]} >= 32'(depth));
    endfunction

endpackage

// File: rtl/data_memory_responder_if.sv
// Load/store request and response channels, both valid/ready.
// master = CPU-side initiator, slave = memory responder.
interface data_memory_responder_if;
    import mem_rsp_pkg::*;

    logic                  req_valid;
    logic                  req_ready;
    logic                  req_write;
    logic [31:0]           req_addr;
    logic [31:0]           req_wdata;
    logic [WORD_BYTES-1:0] req_wstrb;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [31:0]           rsp_rdata;
    logic                  rsp_error;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, req_wstrb, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_error
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, req_wstrb, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_error
    );

endinterface

// File: rtl/byte_strobe_merge.sv
// Combinational byte merge: each set strobe bit replaces the matching byte of
// the old word with the store data; zero latency, no flow control.
module byte_strobe_merge
    import mem_rsp_pkg::*;
(
    input  logic [31:0]           old_word,
    input  logic [31:0]           wdata,
    input  logic [WORD_BYTES-1:0] wstrb,
    output logic [31:0]           merged
);

    always_comb begin
        merged = old_word;
        for (int i = 0; i < WORD_BYTES; i++) begin
            if (wstrb[i]) begin
                merged[8*i +: 8] = wdata[8*i +: 8];
            end
        end
    end

endmodule

// File: rtl/data_memory_responder.sv
// Word-addressed data memory with one outstanding request and a fixed access latency;
// the response is held until taken and no new request is accepted meanwhile.
module data_memory_responder
    import mem_rsp_pkg::*;
#(
    parameter int DEPTH   = 32,
    parameter int LATENCY = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    data_memory_responder_if.slave bus,
    input  logic [DEPTH-1:0][31:0] initial_values,
    output logic [DEPTH-1:0][31:0] memory_check
);

    localparam int IDX_W = $clog2(DEPTH);

    generate
        if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
            $error("data_memory_responder: LATENCY must be within 1..15");
        end
    endgenerate

    rsp_state_t             state;
    rsp_state_t             state_nxt;
    logic [CNT_W-1:0]       cnt;
    logic                   lat_write;
    logic [31:0]            lat_addr;
    logic [31:0]            lat_wdata;
    logic [WORD_BYTES-1:0]  lat_wstrb;
    logic [DEPTH-1:0][31:0] mem;
    logic [IDX_W-1:0]       idx;
    logic                   accept;
    logic                   bad;
    logic [31:0]            merged;

    assign bus.req_ready = (state == RSP_IDLE) && !reset;
    assign bus.rsp_valid = (state == RSP_RESP);
    assign accept        = bus.req_valid && bus.req_ready;
    assign bad           = addr_bad(lat_addr, DEPTH);
    assign idx           = lat_addr[IDX_W+1:2];
    assign memory_check  = mem;

    byte_strobe_merge u_merge (
        .old_word (mem[idx]),
        .wdata    (lat_wdata),
        .wstrb    (lat_wstrb),
        .merged   (merged)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            RSP_IDLE: if (accept)          state_nxt = RSP_WAIT;
            RSP_WAIT: if (cnt == '0)       state_nxt = RSP_RESP;
            RSP_RESP: if (bus.rsp_ready)   state_nxt = RSP_IDLE;
            default:                       state_nxt = RSP_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= RSP_IDLE;
            cnt           <= '0;
            lat_write     <= 1'b0;
            lat_addr      <= '0;
            lat_wdata     <= '0;
            lat_wstrb     <= '0;
            bus.rsp_rdata <= '0;
            bus.rsp_error <= 1'b0;
            mem           <= initial_values;
        end else begin
            state <= state_nxt;
            case (state)
                RSP_IDLE: begin
                    if (accept) begin
                        lat_write <= bus.req_write;
                        lat_addr  <= bus.req_addr;
                        lat_wdata <= bus.req_wdata;
                        lat_wstrb <= bus.req_wstrb;
                        cnt       <= CNT_W'(LATENCY - 1);
                    end
                end
                RSP_WAIT: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else if (bad) begin
                        bus.rsp_rdata <= '0;
                        bus.rsp_error <= 1'b1;
                    end else if (lat_write) begin
                        mem[idx]      <= merged;
                        bus.rsp_rdata <= '0;
                        bus.rsp_error <= 1'b0;
                    end else begin
                        bus.rsp_rdata <= mem[idx];
                        bus.rsp_error <= 1'b0;
                    end
                end
                RSP_RESP: begin
                    if (bus.rsp_ready) begin
                        bus.rsp_rdata <= '0;
                        bus.rsp_error <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_data_memory_responder.sv
// Directed bench: LATENCY=2 responder for protocol/data checks, LATENCY=1 responder
// for back-to-back throughput; expected responses queued at issue, compared on arrival.
module tb_data_memory_responder;
    import mem_rsp_pkg::*;

    localparam int DEPTH = 32;

    logic                   clk = 1'b0;
    logic                   reset;
    logic [DEPTH-1:0][31:0] init_vals;
    logic [DEPTH-1:0][31:0] mem_chk0;
    logic [DEPTH-1:0][31:0] mem_chk1;
    logic [DEPTH-1:0][31:0] exp_mem;

    int          n_assert = 0;
    int          n_fail   = 0;
    logic [32:0] sb0[$];
    logic [32:0] sb1[$];

    data_memory_responder_if bus0();
    data_memory_responder_if bus1();

    data_memory_responder #(.DEPTH(DEPTH), .LATENCY(2)) u_dut0 (
        .clk(clk), .reset(reset), .bus(bus0.slave),
        .initial_values(init_vals), .memory_check(mem_chk0)
    );

    data_memory_responder #(.DEPTH(DEPTH), .LATENCY(1)) u_dut1 (
        .clk(clk), .reset(reset), .bus(bus1.slave),
        .initial_values(init_vals), .memory_check(mem_chk1)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_mem(input string tag);
        int bad_i;
        bad_i = -1;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (mem_chk0[i] !== exp_mem[i]) bad_i = i;
        end
        n_assert++;
        assert (bad_i == -1) else begin
            n_fail++;
            $error("FAIL %s: word %0d observed %h expected %h",
                   tag, bad_i, mem_chk0[bad_i], exp_mem[bad_i]);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one request on bus0, model it, then check latency, payload and release.
    task automatic send(input string tag, input logic wr, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] strb, input int hold);
        logic        bad;
        logic [29:0] widx;
        logic [31:0] exp_rd;
        logic [32:0] e;
        int          n;
        widx   = addr[31:2];
        bad    = (addr[1:0] != 2'b00) || ({2'b00, widx} >= 32'(DEPTH));
        exp_rd = '0;
        if (!bad && !wr) exp_rd = exp_mem[widx[4:0]];
        if (!bad && wr) begin
            for (int i = 0; i < 4; i++) begin
                if (strb[i]) exp_mem[widx[4:0]][8*i +: 8] = wdata[8*i +: 8];
            end
        end
        sb0.push_back({bad, exp_rd});

        bus0.rsp_ready = (hold == 0);
        bus0.req_write = wr;
        bus0.req_addr  = addr;
        bus0.req_wdata = wdata;
        bus0.req_wstrb = strb;
        bus0.req_valid = 1'b1;
        n = 0;
        while (bus0.req_ready !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        if (n >= 20) check({tag, " accept_timeout"}, bus0.req_ready, 1);
        tick();
        // Corrupt the request lines after the accept edge; they must not matter.
        bus0.req_valid = 1'b0;
        bus0.req_write = ~wr;
        bus0.req_addr  = 32'hFFFF_FFFF;
        bus0.req_wdata = ~wdata;
        bus0.req_wstrb = ~strb;

        n = 0;
        while (bus0.rsp_valid !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        check({tag, " latency"}, n, 2);
        e = sb0.pop_front();
        check({tag, " rdata"}, bus0.rsp_rdata, e[31:0]);
        check({tag, " error"}, {31'd0, bus0.rsp_error}, {31'd0, e[32]});

        if (hold > 0) begin
            for (int k = 0; k < hold; k++) begin
                check({tag, " held rsp_valid"}, {31'd0, bus0.rsp_valid}, 1);
                check({tag, " held rdata"}, bus0.rsp_rdata, e[31:0]);
                check({tag, " held req_ready"}, {31'd0, bus0.req_ready}, 0);
                tick();
            end
            bus0.rsp_ready = 1'b1;
        end
        tick();
        check({tag, " rsp_valid after handshake"}, {31'd0, bus0.rsp_valid}, 0);
        check({tag, " req_ready after handshake"}, {31'd0, bus0.req_ready}, 1);
        check({tag, " rdata after handshake"}, bus0.rsp_rdata, 0);
    endtask

    initial begin
        logic rdy[16];
        logic rv[16];
        logic [32:0] e1;
        int   last_rdy;
        int   seen;

        for (int i = 0; i < DEPTH; i++) begin
            init_vals[i] = {8'(i), 8'hA5, 8'(i * 3), 8'h5A};
        end
        init_vals[3] = 32'hDEADBEEF;
        init_vals[4] = 32'hAABBCCDD;
        exp_mem      = init_vals;

        reset          = 1'b1;
        bus0.req_valid = 1'b0;
        bus0.req_write = 1'b0;
        bus0.req_addr  = '0;
        bus0.req_wdata = '0;
        bus0.req_wstrb = '0;
        bus0.rsp_ready = 1'b1;
        bus1.req_valid = 1'b0;
        bus1.req_write = 1'b0;
        bus1.req_addr  = '0;
        bus1.req_wdata = '0;
        bus1.req_wstrb = '0;
        bus1.rsp_ready = 1'b1;

        repeat (3) tick();
        check("reset req_ready", {31'd0, bus0.req_ready}, 0);
        check("reset rsp_valid", {31'd0, bus0.rsp_valid}, 0);
        check("reset rdata", bus0.rsp_rdata, 0);
        check("reset error", {31'd0, bus0.rsp_error}, 0);
        check_mem("reset mem image");
        reset = 1'b0;
        #1;
        check("post-reset req_ready", {31'd0, bus0.req_ready}, 1);

        // Load, partial store, read-back, empty-strobe store.
        send("t1 load 0x0C", 1'b0, 32'h0000_000C, 32'h0, 4'hF, 0);
        send("t2 store 0x10", 1'b1, 32'h0000_0010, 32'h1122_3344, 4'b0101, 0);
        check("t2 mem[4]", mem_chk0[4], 32'hAA22CC44);
        send("t2 load 0x10", 1'b0, 32'h0000_0010, 32'h0, 4'h0, 0);
        send("wstrb0 store 0x14", 1'b1, 32'h0000_0014, 32'hFFFF_FFFF, 4'b0000, 0);
        check_mem("wstrb0 mem image");

        // Errors: misaligned, index == DEPTH, high-bit alias, erroneous store.
        send("t3 load 0x06", 1'b0, 32'h0000_0006, 32'h0, 4'hF, 0);
        send("t3 load 0x80", 1'b0, 32'h0000_0080, 32'h0, 4'hF, 0);
        send("t3 load alias", 1'b0, 32'h1000_0004, 32'h0, 4'hF, 0);
        send("t3 store 0x80", 1'b1, 32'h0000_0080, 32'h5555_5555, 4'hF, 0);
        check_mem("t3 mem image");

        send("t4 held load", 1'b0, 32'h0000_000C, 32'h0, 4'h0, 5);

        // Reset while a store sits in WAIT.
        bus0.req_write = 1'b1;
        bus0.req_addr  = 32'h0;
        bus0.req_wdata = 32'h1234_5678;
        bus0.req_wstrb = 4'hF;
        bus0.req_valid = 1'b1;
        check("t5 ready before accept", {31'd0, bus0.req_ready}, 1);
        tick();
        bus0.req_valid = 1'b0;
        check("t5 in wait rsp_valid", {31'd0, bus0.rsp_valid}, 0);
        reset = 1'b1;
        repeat (2) tick();
        check("t5 req_ready in reset", {31'd0, bus0.req_ready}, 0);
        reset = 1'b0;
        exp_mem = init_vals;
        #1;
        check("t5 req_ready after release", {31'd0, bus0.req_ready}, 1);
        seen = 0;
        for (int k = 0; k < 10; k++) begin
            if (bus0.rsp_valid === 1'b1) seen++;
            tick();
        end
        check("t5 spurious responses", seen, 0);
        check("t5 mem[0]", mem_chk0[0], init_vals[0]);
        check_mem("t5 mem image");
        send("t5 load 0x00", 1'b0, 32'h0, 32'h0, 4'h0, 0);

        // LATENCY=1, requests always pending, response always taken.
        bus1.req_addr  = 32'h0000_000C;
        bus1.req_write = 1'b0;
        bus1.req_valid = 1'b1;
        for (int s = 0; s < 16; s++) begin
            rdy[s] = bus1.req_ready;
            rv[s]  = bus1.rsp_valid;
            if (rv[s] === 1'b1) begin
                if (sb1.size() > 0) begin
                    e1 = sb1.pop_front();
                    check("t6 rdata", bus1.rsp_rdata, e1[31:0]);
                end else begin
                    check("t6 unexpected response", {31'd0, bus1.rsp_valid}, 0);
                end
            end
            if (rdy[s] === 1'b1 && s < 14) sb1.push_back({1'b0, init_vals[3]});
            if (s == 13) bus1.req_valid = 1'b0;
            tick();
        end
        bus1.req_valid = 1'b0;
        check("t6 first ready", {31'd0, rdy[0]}, 1);
        for (int s = 2; s < 16; s++) begin
            check($sformatf("t6 rsp_valid sample %0d", s), {31'd0, rv[s]}, {31'd0, rdy[s-2]});
        end
        last_rdy = 0;
        for (int s = 1; s < 14; s++) begin
            if (rdy[s] === 1'b1) begin
                check($sformatf("t6 accept spacing at %0d", s), s - last_rdy, 3);
                last_rdy = s;
            end
        end
        check("t6 accepts seen", last_rdy, 12);
        check("t6 scoreboard drained", sb1.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
